// File: rtl/layer_seq_pkg.sv
// ============================================================================
// layer_pkg : shared constants for the CNN layer sequencer
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package layer_pkg;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t FETCH  = 3'd1;
  localparam state_t DRAIN  = 3'd2;
  localparam state_t LAUNCH = 3'd3;
  localparam state_t RUN    = 3'd4;
  localparam state_t DONE   = 3'd5;
  localparam state_t ERR    = 3'd6;

  localparam logic [3:0] LT_CONV = 4'd0;
  localparam logic [3:0] LT_POOL = 4'd1;

  localparam logic [1:0] OWN_SEQ  = 2'd0;
  localparam logic [1:0] OWN_CONV = 2'd1;
  localparam logic [1:0] OWN_POOL = 2'd2;

  // Descriptor word0 field positions
  localparam int F_TYPE_LSB   = 28;
  localparam int F_TYPE_W     = 4;
  localparam int F_LAST_BIT   = 27;
  localparam int F_NK_LSB     = 22;
  localparam int F_NK_W       = 5;
  localparam int F_DEPTH_LSB  = 17;
  localparam int F_DEPTH_W    = 5;
  localparam int F_WIDTH_LSB  = 11;
  localparam int F_WIDTH_W    = 6;
  localparam int F_HEIGHT_LSB = 5;
  localparam int F_HEIGHT_W   = 6;

  localparam int DESC_WORDS = 4;

endpackage

`default_nettype wire

// File: rtl/layer_seq_if.sv
// ============================================================================
// layer_seq_if : DRAM, engine handshake and config bus of the layer sequencer
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

interface layer_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  start;
  logic [DATA_WIDTH-1:0] dram_data_in;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic                  dram_en_rd;
  logic [1:0]            dram_owner;
  logic                  conv_enable;
  logic                  pool_enable;
  logic                  conv_done;
  logic                  pool_done;
  logic [4:0]            cfg_num_knls;
  logic [4:0]            cfg_depth;
  logic [5:0]            cfg_width;
  logic [5:0]            cfg_height;
  logic [ADDR_WIDTH-1:0] cfg_wts_base;
  logic [ADDR_WIDTH-1:0] cfg_ifmap_base;
  logic [ADDR_WIDTH-1:0] cfg_ofmap_base;
  logic [2:0]            layer_idx;
  logic                  busy;
  logic                  all_done;
  logic                  err;

  modport seq (
    input  start, dram_data_in, conv_done, pool_done,
    output dram_addr, dram_en_rd, dram_owner, conv_enable, pool_enable,
           cfg_num_knls, cfg_depth, cfg_width, cfg_height,
           cfg_wts_base, cfg_ifmap_base, cfg_ofmap_base,
           layer_idx, busy, all_done, err
  );

  modport env (
    output start, dram_data_in, conv_done, pool_done,
    input  dram_addr, dram_en_rd, dram_owner, conv_enable, pool_enable,
           cfg_num_knls, cfg_depth, cfg_width, cfg_height,
           cfg_wts_base, cfg_ifmap_base, cfg_ofmap_base,
           layer_idx, busy, all_done, err
  );
endinterface

`default_nettype wire

// File: rtl/layer_seq_desc_regs.sv
// ============================================================================
// desc_regs : captures descriptor words and decodes the layer config fields
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module desc_regs
  import layer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  cap,
  input  logic [1:0]            word_idx,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [3:0]            layer_type,
  output logic                  last,
  output logic [4:0]            num_knls,
  output logic [4:0]            depth,
  output logic [5:0]            width,
  output logic [5:0]            height,
  output logic [ADDR_WIDTH-1:0] wts_base,
  output logic [ADDR_WIDTH-1:0] ifmap_base,
  output logic [ADDR_WIDTH-1:0] ofmap_base,
  output logic                  legal
);

  logic [3:0]            r_type;
  logic                  r_last;
  logic [4:0]            r_nk;
  logic [4:0]            r_depth;
  logic [5:0]            r_width;
  logic [5:0]            r_height;
  logic [ADDR_WIDTH-1:0] r_wts;
  logic [ADDR_WIDTH-1:0] r_ifm;
  logic [ADDR_WIDTH-1:0] r_ofm;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_type   <= '0;
      r_last   <= 1'b0;
      r_nk     <= '0;
      r_depth  <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_wts    <= '0;
      r_ifm    <= '0;
      r_ofm    <= '0;
    end else if (cap) begin
      case (word_idx)
        2'd0: begin
          r_type   <= word[F_TYPE_LSB   +: F_TYPE_W];
          r_last   <= word[F_LAST_BIT];
          r_nk     <= word[F_NK_LSB     +: F_NK_W];
          r_depth  <= word[F_DEPTH_LSB  +: F_DEPTH_W];
          r_width  <= word[F_WIDTH_LSB  +: F_WIDTH_W];
          r_height <= word[F_HEIGHT_LSB +: F_HEIGHT_W];
        end
        2'd1:    r_wts <= word[ADDR_WIDTH-1:0];
        2'd2:    r_ifm <= word[ADDR_WIDTH-1:0];
        default: r_ofm <= word[ADDR_WIDTH-1:0];
      endcase
    end
  end

  // Reserved word0 bits and address-word upper bits carry no meaning
  logic w_unused;
  assign w_unused = &{1'b0, word[F_HEIGHT_LSB-1:0], word[DATA_WIDTH-1:ADDR_WIDTH]};

  assign layer_type = r_type;
  assign last       = r_last;
  assign num_knls   = r_nk;
  assign depth      = r_depth;
  assign width      = r_width;
  assign height     = r_height;
  assign wts_base   = r_wts;
  assign ifmap_base = r_ifm;
  assign ofmap_base = r_ofm;
  assign legal      = ((r_type == LT_CONV) || (r_type == LT_POOL)) &&
                      (r_nk != '0) && (r_depth != '0);

endmodule

`default_nettype wire

// File: rtl/layer_seq.sv
// ============================================================================
// layer_seq : fetches layer descriptors and launches conv/pool engines in turn
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module layer_seq #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] DESC_BASE  = 18'h3F000,
  parameter int                    DESC_WORDS = 4,
  parameter int                    MAX_LAYERS = 8
) (
  input  logic      clk,
  input  logic      srstn,
  layer_seq_if.seq  bus
);
  import layer_pkg::*;

  localparam logic [1:0] c_LAST_WORD = 2'(DESC_WORDS - 1);
  localparam logic [2:0] c_LAST_IDX  = 3'(MAX_LAYERS - 1);

  state_t     r_state;
  logic [1:0] r_word;
  logic [2:0] r_layer_idx;
  logic       r_advance;
  logic       r_err;

  logic [3:0]            w_type;
  logic                  w_last;
  logic                  w_legal;
  logic                  w_cap;
  logic [1:0]            w_cap_idx;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [1:0]            w_owner;
  logic                  w_eng_done;
  logic                  w_fetch;
  logic                  w_owned;

  // Read data lags its address by one cycle, so capture trails the read counter
  assign w_fetch   = (r_state == FETCH);
  assign w_cap     = (w_fetch && (r_word != 2'd0)) || (r_state == DRAIN);
  assign w_cap_idx = (r_state == DRAIN) ? c_LAST_WORD : (r_word - 2'd1);
  assign w_rd_addr = DESC_BASE + ADDR_WIDTH'({r_layer_idx, r_word});

  desc_regs #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_desc_regs (
    .clk        (clk),
    .srstn      (srstn),
    .cap        (w_cap),
    .word_idx   (w_cap_idx),
    .word       (bus.dram_data_in),
    .layer_type (w_type),
    .last       (w_last),
    .num_knls   (bus.cfg_num_knls),
    .depth      (bus.cfg_depth),
    .width      (bus.cfg_width),
    .height     (bus.cfg_height),
    .wts_base   (bus.cfg_wts_base),
    .ifmap_base (bus.cfg_ifmap_base),
    .ofmap_base (bus.cfg_ofmap_base),
    .legal      (w_legal)
  );

  assign w_owner    = (w_type == LT_POOL) ? OWN_POOL : OWN_CONV;
  assign w_eng_done = (w_type == LT_POOL) ? bus.pool_done : bus.conv_done;
  // r_advance marks the gap cycle after a non-final done: the engine has released DRAM
  assign w_owned    = (r_state == LAUNCH) || ((r_state == RUN) && !r_advance);

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_layer_idx <= '0;
      r_advance   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= FETCH;
            r_word      <= '0;
            r_layer_idx <= '0;
            r_err       <= 1'b0;
          end
        end
        FETCH: begin
          r_word <= r_word + 2'd1;
          if (r_word == c_LAST_WORD) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_legal) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else begin
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state   <= RUN;
          r_advance <= 1'b0;
        end
        RUN: begin
          if (r_advance) begin
            r_advance <= 1'b0;
            r_word    <= '0;
            r_state   <= FETCH;
          end else if (w_eng_done) begin
            if (w_last) begin
              r_state <= DONE;
            end else if (r_layer_idx == c_LAST_IDX) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_layer_idx <= r_layer_idx + 3'd1;
              r_advance   <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dram_en_rd  = w_fetch;
  assign bus.dram_addr   = w_fetch ? w_rd_addr : '0;
  assign bus.dram_owner  = w_owned ? w_owner : OWN_SEQ;
  assign bus.conv_enable = (r_state == LAUNCH) && (w_type == LT_CONV);
  assign bus.pool_enable = (r_state == LAUNCH) && (w_type == LT_POOL);
  assign bus.layer_idx   = r_layer_idx;
  assign bus.busy        = (r_state == FETCH) || (r_state == DRAIN) ||
                           (r_state == LAUNCH) || (r_state == RUN);
  assign bus.all_done    = (r_state == DONE);
  assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_layer_seq.sv
// ============================================================================
// tb_layer_seq : scoreboard bench for layer_seq with a descriptor DRAM model
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_layer_seq;

  localparam logic [17:0] DESC_BASE = 18'h3F000;

  // Event kinds: 0 conv launch, 1 pool launch, 2 all_done, 3 err
  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic clk;
  logic srstn;
  int   cyc;
  int   t0;
  int   n_chk;
  int   n_err;
  logic err_q;

  ev_t         evq[$];
  logic [17:0] rdq[$];

  logic [31:0] mem [0:63];
  int          d_type [0:7];
  int          d_nk   [0:7];
  int          d_dp   [0:7];
  int          d_wd   [0:7];
  int          d_ht   [0:7];
  logic [17:0] d_wts  [0:7];
  logic [17:0] d_ifm  [0:7];
  logic [17:0] d_ofm  [0:7];

  layer_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) bus ();

  layer_seq #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (18),
    .DESC_BASE  (DESC_BASE),
    .DESC_WORDS (4),
    .MAX_LAYERS (8)
  ) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Descriptor DRAM: one-cycle read latency, junk when not reading
  always @(posedge clk)
    bus.dram_data_in <= bus.dram_en_rd ? mem[6'(bus.dram_addr - DESC_BASE)] : 32'hDEADBEEF;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_desc(input int i, input int ty, input int last, input int nk, input int dp,
                          input int wd, input int ht, input int wts, input int ifm, input int ofm);
    d_type[i] = ty; d_nk[i] = nk; d_dp[i] = dp; d_wd[i] = wd; d_ht[i] = ht;
    d_wts[i] = 18'(wts); d_ifm[i] = 18'(ifm); d_ofm[i] = 18'(ofm);
    mem[i*4]   = {4'(ty), 1'(last), 5'(nk), 5'(dp), 6'(wd), 6'(ht), 5'b10101};
    mem[i*4+1] = {14'h2AAA, 18'(wts)};
    mem[i*4+2] = {14'h1555, 18'(ifm)};
    mem[i*4+3] = {14'h3FFF, 18'(ofm)};
  endtask

  task automatic push_ev(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx;
    evq.push_back(e);
  endtask

  task automatic push_reads(input int idx, input int n);
    for (int k = 0; k < n; k++) rdq.push_back(DESC_BASE + 18'(idx * 4 + k));
  endtask

  // Called at a negedge; returns one negedge later with start released
  task automatic start_run(input int nrd, input bit do_launch);
    bus.start = 1'b1;
    t0 = cyc;
    push_reads(0, nrd);
    if (do_launch) push_ev(d_type[0], t0 + 6, 0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compares every read and every launch/done/error event against the queues
  always @(negedge clk) begin
    int  k;
    ev_t e;
    logic [17:0] a;
    if (bus.dram_en_rd) begin
      if (rdq.size() == 0) chk_val("rd_unexpected", 32'(bus.dram_addr), 32'h0);
      else begin
        a = rdq.pop_front();
        chk_val("rd_addr", 32'(bus.dram_addr), 32'(a));
      end
    end
    k = -1;
    if (bus.conv_enable)            k = 0;
    else if (bus.pool_enable)       k = 1;
    else if (bus.all_done)          k = 2;
    else if (bus.err && !err_q)     k = 3;
    if (k >= 0) begin
      if (evq.size() == 0) chk_val("ev_unexpected", 32'(k), 32'hFF);
      else begin
        e = evq.pop_front();
        chk_val("ev_kind", 32'(k), 32'(e.kind));
        chk_val("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk_val("ev_layer_idx", 32'(bus.layer_idx), 32'(e.idx));
        if (k < 2) begin
          chk_val("launch_owner", 32'(bus.dram_owner), 32'(k + 1));
          chk_val("launch_busy", 32'(bus.busy), 32'h1);
          chk_val("cfg_num_knls", 32'(bus.cfg_num_knls), 32'(d_nk[e.idx]));
          chk_val("cfg_depth", 32'(bus.cfg_depth), 32'(d_dp[e.idx]));
          chk_val("cfg_width", 32'(bus.cfg_width), 32'(d_wd[e.idx]));
          chk_val("cfg_height", 32'(bus.cfg_height), 32'(d_ht[e.idx]));
          chk_val("cfg_wts_base", 32'(bus.cfg_wts_base), 32'(d_wts[e.idx]));
          chk_val("cfg_ifmap_base", 32'(bus.cfg_ifmap_base), 32'(d_ifm[e.idx]));
          chk_val("cfg_ofmap_base", 32'(bus.cfg_ofmap_base), 32'(d_ofm[e.idx]));
        end else begin
          chk_val("end_owner", 32'(bus.dram_owner), 32'h0);
          chk_val("end_busy", 32'(bus.busy), 32'h0);
          if (k == 3) chk_val("err_no_all_done", 32'(bus.all_done), 32'h0);
        end
      end
    end
    err_q = bus.err;
  end

  initial begin
    n_chk = 0; n_err = 0; err_q = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    srstn = 1'b0;
    bus.start = 1'b0; bus.conv_done = 1'b0; bus.pool_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk_val("rst_busy", 32'(bus.busy), 32'h0);
    chk_val("rst_owner", 32'(bus.dram_owner), 32'h0);
    chk_val("rst_en_rd", 32'(bus.dram_en_rd), 32'h0);
    chk_val("rst_addr", 32'(bus.dram_addr), 32'h0);
    chk_val("rst_enables", 32'({bus.conv_enable, bus.pool_enable}), 32'h0);
    chk_val("rst_all_done", 32'(bus.all_done), 32'h0);
    chk_val("rst_err", 32'(bus.err), 32'h0);
    chk_val("rst_layer_idx", 32'(bus.layer_idx), 32'h0);
    chk_val("rst_cfg", 32'({bus.cfg_num_knls, bus.cfg_depth, bus.cfg_width, bus.cfg_height}), 32'h0);
    chk_val("rst_bases", 32'(bus.cfg_wts_base | bus.cfg_ifmap_base | bus.cfg_ofmap_base), 32'h0);
    srstn = 1'b1;
    @(negedge clk);

    // 1: single conv layer; a done coinciding with LAUNCH must be ignored
    set_desc(0, 0, 1, 16, 6, 14, 28, 0, 65536, 131072);
    start_run(4, 1'b1);
    wait_until(t0 + 6);
    bus.conv_done = 1'b1;
    @(negedge clk);
    bus.conv_done = 1'b0;
    chk_val("t1_owner_run", 32'(bus.dram_owner), 32'h1);
    chk_val("t1_busy_run", 32'(bus.busy), 32'h1);
    wait_until(t0 + 10);
    bus.conv_done = 1'b1;
    push_ev(2, cyc + 1, 0);
    @(negedge clk);
    bus.conv_done = 1'b0;
    @(negedge clk);
    chk_val("t1_owner_idle", 32'(bus.dram_owner), 32'h0);

    // 2: conv then pool
    set_desc(0, 0, 0, 8, 3, 10, 12, 18'h00100, 18'h01000, 18'h02000);
    set_desc(1, 1, 1, 4, 8, 5, 7, 18'h3FFFF, 18'h12345, 18'h00001);
    start_run(4, 1'b1);
    wait_until(t0 + 9);
    bus.conv_done = 1'b1;
    push_reads(1, 4);
    push_ev(1, cyc + 7, 1);
    @(negedge clk);
    bus.conv_done = 1'b0;
    chk_val("t2_owner_gap", 32'(bus.dram_owner), 32'h0);
    wait_until(t0 + 18);
    bus.pool_done = 1'b1;
    push_ev(2, cyc + 1, 1);
    @(negedge clk);
    bus.pool_done = 1'b0;
    repeat (2) @(negedge clk);

    // 3: illegal type, then a fresh start clears err
    set_desc(0, 15, 1, 4, 4, 4, 4, 1, 2, 3);
    start_run(4, 1'b0);
    push_ev(3, t0 + 6, 0);
    wait_until(t0 + 8);
    chk_val("t3_err", 32'(bus.err), 32'h1);
    chk_val("t3_busy", 32'(bus.busy), 32'h0);
    set_desc(0, 1, 1, 2, 2, 9, 9, 5, 6, 7);
    start_run(4, 1'b1);
    chk_val("t3_err_cleared", 32'(bus.err), 32'h0);
    wait_until(t0 + 8);
    bus.pool_done = 1'b1;
    push_ev(2, cyc + 1, 0);
    @(negedge clk);
    bus.pool_done = 1'b0;
    repeat (2) @(negedge clk);

    // 4: eight non-last descriptors run into the layer limit
    for (int i = 0; i < 8; i++)
      set_desc(i, i % 2, 0, i + 1, i + 2, i + 3, i + 4, i * 1000, i * 2000 + 7, i * 3000 + 9);
    begin
      int tl;
      start_run(4, 1'b1);
      tl = t0 + 6;
      for (int i = 0; i < 8; i++) begin
        wait_until(tl + 2);
        if (d_type[i] == 1) bus.pool_done = 1'b1;
        else bus.conv_done = 1'b1;
        if (i < 7) begin
          push_reads(i + 1, 4);
          push_ev(d_type[i + 1], cyc + 7, i + 1);
          tl = cyc + 7;
        end else begin
          push_ev(3, cyc + 1, 7);
        end
        @(negedge clk);
        bus.conv_done = 1'b0;
        bus.pool_done = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    chk_val("t4_err", 32'(bus.err), 32'h1);

    // 5: wrong engine's done ignored during a conv RUN
    set_desc(0, 0, 1, 31, 31, 63, 63, 11, 22, 33);
    start_run(4, 1'b1);
    wait_until(t0 + 8);
    bus.pool_done = 1'b1;
    @(negedge clk);
    bus.pool_done = 1'b0;
    chk_val("t5_owner_hold", 32'(bus.dram_owner), 32'h1);
    chk_val("t5_busy_hold", 32'(bus.busy), 32'h1);
    wait_until(t0 + 11);
    bus.conv_done = 1'b1;
    push_ev(2, cyc + 1, 0);
    @(negedge clk);
    bus.conv_done = 1'b0;
    repeat (2) @(negedge clk);

    // 6: reset during FETCH word 2, then a clean restart
    set_desc(0, 0, 1, 9, 9, 9, 9, 100, 200, 300);
    start_run(3, 1'b0);
    wait_until(t0 + 3);
    srstn = 1'b0;
    @(negedge clk);
    chk_val("t6_en_rd", 32'(bus.dram_en_rd), 32'h0);
    chk_val("t6_busy", 32'(bus.busy), 32'h0);
    chk_val("t6_owner", 32'(bus.dram_owner), 32'h0);
    chk_val("t6_nk", 32'(bus.cfg_num_knls), 32'h0);
    chk_val("t6_layer_idx", 32'(bus.layer_idx), 32'h0);
    srstn = 1'b1;
    @(negedge clk);
    start_run(4, 1'b1);
    wait_until(t0 + 8);
    bus.conv_done = 1'b1;
    push_ev(2, cyc + 1, 0);
    @(negedge clk);
    bus.conv_done = 1'b0;
    repeat (3) @(negedge clk);

    chk_val("events_left", 32'(evq.size()), 32'h0);
    chk_val("reads_left", 32'(rdq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
